uart_rx_frame: RTL and testbench

Parametrised UART receive engine, successor to the fixed 8N1 receiver. It oversamples an asynchronous serial line using the shared baud `tic` strobe and supports configurable data width, optional even/odd parity and configurable stop length. It rejects false start bits and reports parity and framing errors per frame. Received words are delivered through a valid/ready holding register with overrun detection, which sits between the pad-side `rx_data` line and the host FIFO or bus logic.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync2.sv | 28 ++
 rtl/uart_rx_frame.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART
// receive and transmit engines.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous
// level input, with a selectable reset value.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with parity,
// framing checks and a valid/ready holding register.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_TICS  = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_data,
  input  logic                 tic,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] dout,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TMAX =
    (OVERSAMPLE > STOP_TICS) ? OVERSAMPLE : STOP_TICS;
  localparam int TW = $clog2(TMAX);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] HALF_LAST =
    TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST =
    TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST =
    TW'(STOP_TICS - 1);
  localparam logic [BW-1:0] DATA_LAST =
    BW'(DATA_BITS - 1);
  localparam logic ODD_BIT = (PARITY_ODD == PAR_ODD);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_rx_frame: DATA_BITS must be 5..9");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0)
  begin : g_bad_os
    $error("uart_rx_frame: OVERSAMPLE must be even, >= 8");
  end
  if (STOP_TICS < OVERSAMPLE) begin : g_bad_stop
    $error("uart_rx_frame: STOP_TICS must be >= OVERSAMPLE");
  end
  if (PARITY_EN < 0 || PARITY_EN > 1) begin : g_bad_pen
    $error("uart_rx_frame: PARITY_EN must be 0 or 1");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_podd
    $error("uart_rx_frame: PARITY_ODD must be 0 or 1");
  end

  logic rxs;

  uart_sync2 #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx_data),
    .q    (rxs)
  );

  rx_state_t            state_q, state_d;
  logic [TW-1:0]        tic_q, tic_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 fperr_q, fperr_d;
  logic                 arm_q, arm_d;
  logic                 frame_done;
  logic                 frame_ferr;

  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 hperr_q, hperr_d;
  logic                 hferr_q, hferr_d;
  logic                 ovr_q, ovr_d;

  // frame FSM: start qualification, bit sampling, checks
  always_comb begin
    state_d    = state_q;
    tic_d      = tic_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    par_d      = par_q;
    fperr_d    = fperr_q;
    arm_d      = arm_q;
    frame_done = 1'b0;
    frame_ferr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rxs) begin
          arm_d = 1'b1;
        end else if (arm_q) begin
          state_d = START;
          tic_d   = '0;
        end
      end
      START: begin
        if (tic) begin
          if (tic_q == HALF_LAST) begin
            tic_d = '0;
            if (!rxs) begin
              state_d = DATA;
              bit_d   = '0;
              par_d   = 1'b0;
              fperr_d = 1'b0;
            end else begin
              state_d = IDLE;
              arm_d   = 1'b0;
            end
          end else begin
            tic_d = tic_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (tic) begin
          if (tic_q == BIT_LAST) begin
            tic_d = '0;
            sh_d  = {rxs, sh_q[DATA_BITS-1:1]};
            par_d = par_q ^ rxs;
            bit_d = bit_q + BW'(1);
            if (bit_q == DATA_LAST) begin
              bit_d   = '0;
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
          end else begin
            tic_d = tic_q + TW'(1);
          end
        end
      end
      PARITY: begin
        if (tic) begin
          if (tic_q == BIT_LAST) begin
            tic_d   = '0;
            fperr_d = par_q ^ rxs ^ ODD_BIT;
            state_d = STOP;
          end else begin
            tic_d = tic_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (tic) begin
          if (tic_q == STOP_LAST) begin
            tic_d      = '0;
            frame_done = 1'b1;
            frame_ferr = ~rxs;
            arm_d      = 1'b0;
            state_d    = IDLE;
          end else begin
            tic_d = tic_q + TW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tic_d   = '0;
        bit_d   = '0;
        arm_d   = 1'b0;
      end
    endcase
  end

  // holding register: load, drain and overrun detection
  always_comb begin
    valid_d = valid_q;
    dout_d  = dout_q;
    hperr_d = hperr_q;
    hferr_d = hferr_q;
    ovr_d   = 1'b0;
    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
    if (frame_done) begin
      if (!valid_q || rx_ready) begin
        valid_d = 1'b1;
        dout_d  = sh_q;
        hperr_d = fperr_q;
        hferr_d = frame_ferr;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tic_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      fperr_q <= 1'b0;
      arm_q   <= 1'b0;
      valid_q <= 1'b0;
      dout_q  <= '0;
      hperr_q <= 1'b0;
      hferr_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tic_q   <= tic_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      fperr_q <= fperr_d;
      arm_q   <= arm_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
      hperr_q <= hperr_d;
      hferr_q <= hferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_valid   = valid_q;
  assign dout       = dout_q;
  assign parity_err = hperr_q;
  assign frame_err  = hferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed checks of the UART receiver
// in 8N1 and 7E1 configurations.
module tb_uart_rx_frame;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tic = 1'b0;
  int         tdiv = 0;

  logic       rx_a = 1'b1;
  logic       rdy_a = 1'b0;
  logic       val_a;
  logic [7:0] dout_a;
  logic       perr_a;
  logic       ferr_a;
  logic       ovr_a;

  logic       rx_b = 1'b1;
  logic       rdy_b = 1'b0;
  logic       val_b;
  logic [6:0] dout_b;
  logic       perr_b;
  logic       ferr_b;
  logic       ovr_b;

  int n_vec = 0;
  int n_bad = 0;
  int loads_a = 0;
  int ovrs_a = 0;
  logic vprev_a = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tdiv <= (tdiv == 3) ? 0 : tdiv + 1;
    tic  <= (tdiv == 2);
  end

  always @(negedge clk) begin
    vprev_a <= val_a;
    if (val_a && !vprev_a) loads_a <= loads_a + 1;
    if (ovr_a) ovrs_a <= ovrs_a + 1;
  end

  uart_rx_frame dut_a (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_a),
    .tic       (tic),
    .rx_valid  (val_a),
    .rx_ready  (rdy_a),
    .dout      (dout_a),
    .parity_err(perr_a),
    .frame_err (ferr_a),
    .overrun   (ovr_a)
  );

  uart_rx_frame #(
    .DATA_BITS (7),
    .PARITY_EN (1),
    .PARITY_ODD(0)
  ) dut_b (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_b),
    .tic       (tic),
    .rx_valid  (val_b),
    .rx_ready  (rdy_b),
    .dout      (dout_b),
    .parity_err(perr_b),
    .frame_err (ferr_b),
    .overrun   (ovr_b)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic put(input bit to_b, input logic b);
    if (to_b) rx_b = b;
    else rx_a = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send(
    input bit         to_b,
    input logic [8:0] d,
    input int         nb,
    input bit         use_par,
    input logic       pb,
    input logic       stopb
  );
    put(to_b, 1'b0);
    for (int i = 0; i < nb; i++) put(to_b, d[i]);
    if (use_par) put(to_b, pb);
    put(to_b, stopb);
  endtask

  task automatic drain_a();
    rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
  endtask

  task automatic drain_b();
    rdy_b = 1'b1;
    @(negedge clk);
    rdy_b = 1'b0;
  endtask

  initial begin
    int base_l;
    int base_o;
    bit got;

    repeat (4) @(negedge clk);
    check("rst_valid", 32'(val_a), 0);
    check("rst_dout", 32'(dout_a), 0);
    check("rst_perr", 32'(perr_a), 0);
    check("rst_ferr", 32'(ferr_a), 0);
    check("rst_ovr", 32'(ovr_a), 0);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // 8N1 0xA5, held until ready
    send(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1);
    check("a5_valid", 32'(val_a), 1);
    check("a5_dout", 32'(dout_a), 32'h A5);
    check("a5_perr", 32'(perr_a), 0);
    check("a5_ferr", 32'(ferr_a), 0);
    repeat (100) @(negedge clk);
    check("a5_hold", 32'(val_a), 1);
    check("a5_hold_dout", 32'(dout_a), 32'h A5);
    drain_a();
    check("a5_drained", 32'(val_a), 0);

    // 7E1 0x35: four ones, parity 0 is good
    send(1'b1, 9'h035, 7, 1'b1, 1'b0, 1'b1);
    check("p0_valid", 32'(val_b), 1);
    check("p0_dout", 32'(dout_b), 32'h35);
    check("p0_perr", 32'(perr_b), 0);
    drain_b();
    send(1'b1, 9'h035, 7, 1'b1, 1'b1, 1'b1);
    check("p1_valid", 32'(val_b), 1);
    check("p1_dout", 32'(dout_b), 32'h35);
    check("p1_perr", 32'(perr_b), 1);
    check("p1_ferr", 32'(ferr_b), 0);
    drain_b();
    check("p1_drained", 32'(val_b), 0);

    // low glitch of 4 tics is a false start
    base_l = loads_a;
    rx_a = 1'b0;
    repeat (16) @(negedge clk);
    rx_a = 1'b1;
    repeat (12 * BIT_CLK) @(negedge clk);
    check("glitch_loads", 32'(loads_a - base_l), 0);
    check("glitch_valid", 32'(val_a), 0);

    // break: 0x00 with low stop, then line held low
    base_l = loads_a;
    base_o = ovrs_a;
    for (int i = 0; i < 10; i++) put(1'b0, 1'b0);
    check("brk_valid", 32'(val_a), 1);
    check("brk_dout", 32'(dout_a), 0);
    check("brk_ferr", 32'(ferr_a), 1);
    drain_a();
    repeat (30 * BIT_CLK) @(negedge clk);
    check("brk_loads", 32'(loads_a - base_l), 1);
    check("brk_ovr", 32'(ovrs_a - base_o), 0);
    check("brk_idle", 32'(val_a), 0);
    rx_a = 1'b1;
    repeat (12 * BIT_CLK) @(negedge clk);
    check("brk_after_high", 32'(loads_a - base_l), 1);

    // back-to-back 0x11, 0x22 with no ready
    base_o = ovrs_a;
    send(1'b0, 9'h011, 8, 1'b0, 1'b0, 1'b1);
    send(1'b0, 9'h022, 8, 1'b0, 1'b0, 1'b1);
    check("ovr_valid", 32'(val_a), 1);
    check("ovr_dout", 32'(dout_a), 32'h11);
    check("ovr_pulses", 32'(ovrs_a - base_o), 1);
    drain_a();
    check("ovr_drained", 32'(val_a), 0);

    // same, ready pulsed on completion of 0x22
    base_o = ovrs_a;
    send(1'b0, 9'h011, 8, 1'b0, 1'b0, 1'b1);
    got = 1'b0;
    fork
      send(1'b0, 9'h022, 8, 1'b0, 1'b0, 1'b1);
      begin
        for (int i = 0; i < 20 * BIT_CLK; i++) begin
          @(negedge clk);
          if (dut_a.frame_done) begin
            got = 1'b1;
            rdy_a = 1'b1;
            @(negedge clk);
            rdy_a = 1'b0;
            break;
          end
        end
      end
    join
    check("rdy_seen_done", 32'(got), 1);
    check("rdy_valid", 32'(val_a), 1);
    check("rdy_dout", 32'(dout_a), 32'h22);
    check("rdy_no_ovr", 32'(ovrs_a - base_o), 0);
    drain_a();

    // reset mid-frame with a word already held
    send(1'b0, 9'h033, 8, 1'b0, 1'b0, 1'b1);
    check("pre_rst_valid", 32'(val_a), 1);
    base_o = ovrs_a;
    put(1'b0, 1'b0);
    put(1'b0, 1'b1);
    put(1'b0, 1'b1);
    put(1'b0, 1'b0);
    rx_a = 1'b1;
    repeat (BIT_CLK / 2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(val_a), 0);
    check("mid_rst_dout", 32'(dout_a), 0);
    check("mid_rst_ferr", 32'(ferr_a), 0);
    repeat (12 * BIT_CLK) @(negedge clk);
    check("mid_rst_quiet", 32'(val_a), 0);
    check("mid_rst_ovr", 32'(ovrs_a - base_o), 0);

    send(1'b0, 9'h05A, 8, 1'b0, 1'b0, 1'b1);
    check("5a_valid", 32'(val_a), 1);
    check("5a_dout", 32'(dout_a), 32'h5A);
    check("5a_ferr", 32'(ferr_a), 0);
    drain_a();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
